// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the SEQ sequencing controller.
// Contents: icode constants, Stat codes, controller state enum and the
// is_mem_icode helper that marks instructions touching data memory.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned ADDR_W  = 64;

    localparam logic [ICODE_W-1:0] ICODE_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] ICODE_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] ICODE_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] ICODE_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICODE_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALT
    } state_t;

    // Instructions that issue a data-memory access in the MEMORY stage.
    function automatic logic is_mem_icode(input logic [ICODE_W-1:0] ic);
        case (ic)
            ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_CALL,
            ICODE_RET, ICODE_PUSHQ, ICODE_POPQ: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits for its ack.
// Ports: clk, rst_n, clear (zero the count), req/ack (the request being
// waited on), timeout (combinational: this is the last allowed wait cycle
// and the ack is still absent, so the waiter must give up).
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    // Wait-cycle counter: only unanswered request cycles advance it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (req && !ack) begin
            count <= count + CW'(1);
        end
    end

    // An ack in the final wait cycle wins because timeout requires !ack.
    assign timeout = req && !ack && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/seq_ctrl.sv
// Sequencing controller for the SEQ Y86 core.
// Owns the architectural PC, the Stat register and the retired-instruction
// counter; walks FETCH..PCUPD with one-cycle stage enables and waits on
// imem/dmem req/ack handshakes. Faults (ADR/INS) and HLT park it in HALT
// until reset.
// Ports: clk, rst_n, start; icode/instr_valid from fetch; imem/dmem ack and
// error; PC_new from PC-update logic; PC, imem_req, dmem_req, stage enables,
// stat, halted, instr_count.
module seq_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ICODE_W-1:0]  icode,
    input  logic                instr_valid,
    input  logic                imem_ack,
    input  logic                imem_error,
    input  logic                dmem_ack,
    input  logic                dmem_error,
    input  logic [ADDR_W-1:0]   PC_new,
    output logic [ADDR_W-1:0]   PC,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                fetch_en,
    output logic                decode_en,
    output logic                execute_en,
    output logic                mem_en,
    output logic                wb_en,
    output logic [STAT_W-1:0]   stat,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);

    state_t               state;
    state_t               state_next;
    logic [ICODE_W-1:0]   cur_icode;
    logic                 timeout;
    logic                 timer_clear_c;
    logic                 pc_load_c;
    logic                 stat_load_c;
    logic [STAT_W-1:0]    stat_next_c;
    logic                 icode_load_c;

    // Requests are pure state decodes; the icode is captured at fetch so the
    // MEMORY decision does not depend on fetch inputs later in the instruction.
    assign imem_req      = (state == S_FETCH);
    assign dmem_req      = (state == S_MEMORY) && is_mem_icode(cur_icode);
    assign halted        = (state == S_HALT);
    assign timer_clear_c = (state != S_FETCH) && (state != S_MEMORY);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear_c),
        .req     (imem_req || dmem_req),
        .ack     ((imem_req && imem_ack) || (dmem_req && dmem_ack)),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, stage enables and commit controls.
    always_comb begin
        state_next   = state;
        fetch_en     = 1'b0;
        decode_en    = 1'b0;
        execute_en   = 1'b0;
        mem_en       = 1'b0;
        wb_en        = 1'b0;
        pc_load_c    = 1'b0;
        stat_load_c  = 1'b0;
        stat_next_c  = stat;
        icode_load_c = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (imem_error) begin
                        stat_load_c = 1'b1;
                        stat_next_c = STAT_ADR;
                        state_next  = S_HALT;
                    end else if (!instr_valid) begin
                        stat_load_c = 1'b1;
                        stat_next_c = STAT_INS;
                        state_next  = S_HALT;
                    end else if (icode == ICODE_HALT) begin
                        stat_load_c = 1'b1;
                        stat_next_c = STAT_HLT;
                        state_next  = S_HALT;
                    end else begin
                        fetch_en     = 1'b1;
                        icode_load_c = 1'b1;
                        state_next   = S_DECODE;
                    end
                end else if (timeout) begin
                    stat_load_c = 1'b1;
                    stat_next_c = STAT_ADR;
                    state_next  = S_HALT;
                end
            end
            S_DECODE: begin
                decode_en  = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                execute_en = 1'b1;
                state_next = S_MEMORY;
            end
            S_MEMORY: begin
                if (!is_mem_icode(cur_icode)) begin
                    state_next = S_WRITEBACK;
                end else if (dmem_ack) begin
                    if (dmem_error) begin
                        stat_load_c = 1'b1;
                        stat_next_c = STAT_ADR;
                        state_next  = S_HALT;
                    end else begin
                        mem_en     = 1'b1;
                        state_next = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    stat_load_c = 1'b1;
                    stat_next_c = STAT_ADR;
                    state_next  = S_HALT;
                end
            end
            S_WRITEBACK: begin
                wb_en      = 1'b1;
                state_next = S_PCUPD;
            end
            S_PCUPD: begin
                pc_load_c  = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Architectural state: PC, Stat, retired count and captured icode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            stat        <= STAT_AOK;
            instr_count <= '0;
            cur_icode   <= ICODE_NOP;
        end else begin
            if (pc_load_c) begin
                PC          <= PC_new;
                instr_count <= instr_count + CNT_W'(1);
            end
            if (stat_load_c) stat <= stat_next_c;
            if (icode_load_c) cur_icode <= icode;
        end
    end

endmodule
